adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
- Serial-side model of the 2-channel, 10-bit ADC that adc_driver talks to. It sits on the far end of the cs/din/dout link, in the same clock domain.
- Decodes the command frame from the driver, captures a sample from parallel inputs, and returns a null bit followed by DATA_W data bits.
- Used for on-FPGA loopback and as a synthesizable bench model in place of the real converter.

Parameters:
- DATA_W, 10, sample width and number of data bits returned.
- IDLE_DOUT, 1'b0, level driven on dout_o when no conversion is being returned.

Ports:
- s_clk_i  in  1  system clock; also the serial bit clock; all sampling on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cs_i  in  1  chip select from driver, active low.
- din_i  in  1  command bits from driver.
- dout_o  out  1  registered serial data to driver.
- ch0_data_i  in  DATA_W  channel-0 sample source.
- ch1_data_i  in  DATA_W  channel-1 sample source.
- busy_o  out  1  high from start-bit detect until the last data bit is driven.
- conv_done_o  out  1  one-cycle pulse on the edge that drives the last data bit.
- last_cmd_o  out  3  {SGL, ODD, MSBF} of the last completed command frame.

Behaviour:
- Reset: state=IDLE; dout_o=IDLE_DOUT; busy_o=0; conv_done_o=0; last_cmd_o=0; shift register=0; bit counter=0.
- cs_i high at any edge (including mid-frame): next state IDLE, dout_o=IDLE_DOUT, busy_o=0. No conv_done_o pulse; last_cmd_o is not updated. Reset has priority over cs_i.
- FSM, one din bit per edge while cs_i=0:
  - IDLE: cs_i=0 -> WAIT_START.
  - WAIT_START: din_i=0 ignored (leading zeros allowed); din_i=1 -> GET_SGL, busy_o<=1.
  - GET_SGL: latch SGL -> GET_ODD.
  - GET_ODD: latch ODD -> GET_MSBF.
  - GET_MSBF, on the edge that samples MSBF:
    - capture the sample into the shift register;
    - dout_o<=0 (null bit);
    - bit counter<=0;
    - -> DATA.
  - DATA: each edge drives the next data bit; counter increments. On the edge driving bit DATA_W-1: conv_done_o<=1, last_cmd_o<={SGL,ODD,MSBF} -> DONE.
  - DONE: dout_o<=IDLE_DOUT, busy_o<=0; hold until cs_i=1 -> IDLE. A new frame requires cs_i deassert/reassert.
- Latency: the null bit is visible the cycle after MSBF is sampled. Data bit k is visible k+2 cycles after MSBF is sampled. Frame length = start + 3 command bits + null + DATA_W.
- Bit order: MSBF=1 -> D[DATA_W-1] first; MSBF=0 -> D[0] first, which matches adc_driver's LSB-first assembly.
- Sample selection, captured once per frame at the GET_MSBF edge:
  - SGL=1: ODD=0 -> ch0_data_i; ODD=1 -> ch1_data_i.
  - SGL=0 (pseudo-differential): ODD=0 -> ch0-ch1; ODD=1 -> ch1-ch0. Computed at DATA_W+1 bits; a negative result clamps to 0. No wrap.
- Input changes after capture do not affect the frame in flight.

Optional Feature:
- Macro ADC_RESP_RAMP_EN.
- Defined:
  - Internal per-channel DATA_W-bit ramp registers replace ch0_data_i/ch1_data_i as the sample source.
  - Reset values: ch0 ramp=0, ch1 ramp=DATA_W'h200.
  - The ramp of the channel selected by ODD increments by 1 on each conv_done_o; it wraps from all-ones to 0. An aborted frame does not increment.
  - In differential mode both ramps are used as operands; only the ODD-selected ramp increments.
- Undefined: the ramp logic is absent and the ch*_data_i inputs are used.

Decomposition:
- Shared package/include adc_pkg:
  - FSM state encoding (IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF, DATA, DONE);
  - command field indices (CMD_SGL=2, CMD_ODD=1, CMD_MSBF=0);
  - ADC_DATA_W=10, shared with adc_driver.
- One sub-module, adc_resp_sel: combinational channel/differential select with clamp, plus the optional ramp registers.

Test Plan:
- Reset mid-DATA: rst_i=1 for 1 cycle -> next cycle dout_o=0, busy_o=0, last_cmd_o=0; a following full frame returns correct data.
- SGL=1, ODD=1, MSBF=0, ch1=10'h2A5 -> null 0, then bits 1,0,1,0,0,1,0,1,0,1; conv_done_o pulses once; last_cmd_o=3'b110; adc_driver data_o=10'h2A5.
- SGL=1, ODD=0, MSBF=1, ch0=10'h001, with two leading zeros before the start bit -> null, then 0,0,0,0,0,0,0,0,0,1.
- SGL=0, ODD=0, ch0=300, ch1=100 -> returns 200. Then ch0=100, ch1=300 -> returns 0 (clamp).
- cs_i raised after 4 data bits -> dout_o=IDLE_DOUT the next cycle, no conv_done_o, last_cmd_o unchanged; the next frame is correct.
- ADC_RESP_RAMP_EN: 3 frames on ch0 -> 0, 1, 2. Preset ch0 ramp to 10'h3FF -> returns 1023 then 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC serial link (responder and driver sides).
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 10;

    // Bit positions of the command fields within {SGL, ODD, MSBF}
    localparam int unsigned CMD_SGL  = 2;
    localparam int unsigned CMD_ODD  = 1;
    localparam int unsigned CMD_MSBF = 0;

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StGetSgl,
        StGetOdd,
        StGetMsbf,
        StData,
        StDone
    } resp_state_e;

endpackage

// File: rtl/adc_responder_if.sv
// Serial link, sample sources and status of the ADC responder.
interface adc_responder_if #(
    parameter int unsigned DATA_W = adc_pkg::ADC_DATA_W
);
    logic              cs_i;
    logic              din_i;
    logic              dout_o;
    logic [DATA_W-1:0] ch0_data_i;
    logic [DATA_W-1:0] ch1_data_i;
    logic              busy_o;
    logic              conv_done_o;
    logic [2:0]        last_cmd_o;

    modport master (
        output cs_i, din_i, ch0_data_i, ch1_data_i,
        input  dout_o, busy_o, conv_done_o, last_cmd_o
    );

    modport slave (
        input  cs_i, din_i, ch0_data_i, ch1_data_i,
        output dout_o, busy_o, conv_done_o, last_cmd_o
    );
endinterface

// File: rtl/adc_resp_sel.sv
// Channel / pseudo-differential sample select with clamp at zero.
// With ADC_RESP_RAMP_EN defined, internal ramps replace the channel inputs.
module adc_resp_sel
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sgl,
    input  logic              odd,
    input  logic              advance,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [DATA_W-1:0] ch1_data,
    output logic [DATA_W-1:0] sample
);

    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   diff;

`ifdef ADC_RESP_RAMP_EN
    logic [DATA_W-1:0] ramp0_q;
    logic [DATA_W-1:0] ramp1_q;
    logic              unused_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp0_q <= '0;
            ramp1_q <= DATA_W'('h200);
        end else if (advance) begin
            if (odd) ramp1_q <= ramp1_q + 1'b1;
            else     ramp0_q <= ramp0_q + 1'b1;
        end
    end

    assign src0      = ramp0_q;
    assign src1      = ramp1_q;
    assign unused_ch = ^{ch0_data, ch1_data};
`else
    logic unused_ramp;

    assign src0        = ch0_data;
    assign src1        = ch1_data;
    assign unused_ramp = ^{clk, rst, advance};
`endif

    always_comb begin
        opa    = odd ? src1 : src0;
        opb    = odd ? src0 : src1;
        // One extra bit so a negative difference shows up as the MSB
        diff   = {1'b0, opa} - {1'b0, opb};
        sample = '0;
        if (sgl) begin
            sample = opa;
        end else if (!diff[DATA_W]) begin
            sample = diff[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/adc_responder.sv
// Serial-side ADC model: decodes {start, SGL, ODD, MSBF}, returns null + DATA_W bits.
// Optional macro ADC_RESP_RAMP_EN switches the sample source to internal ramps.
module adc_responder
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W    = ADC_DATA_W,
    parameter logic        IDLE_DOUT = 1'b0
) (
    input  logic           s_clk_i,
    input  logic           rst_i,
    adc_responder_if.slave bus
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    resp_state_e       state_q, state_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sample;

    adc_resp_sel #(
        .DATA_W (DATA_W)
    ) u_sel (
        .clk      (s_clk_i),
        .rst      (rst_i),
        .sgl      (cmd_q[CMD_SGL]),
        .odd      (cmd_q[CMD_ODD]),
        .advance  (done_q),
        .ch0_data (bus.ch0_data_i),
        .ch1_data (bus.ch1_data_i),
        .sample   (sample)
    );

    always_ff @(posedge s_clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            dout_q  <= IDLE_DOUT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= '0;
            cmd_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_d  = last_q;
        cmd_d   = cmd_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        if (bus.cs_i) begin
            // Deselect aborts any frame without touching last_cmd
            state_d = StIdle;
            dout_d  = IDLE_DOUT;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWaitStart;
                StWaitStart: begin
                    if (bus.din_i) begin
                        state_d = StGetSgl;
                        busy_d  = 1'b1;
                    end
                end
                StGetSgl: begin
                    cmd_d[CMD_SGL] = bus.din_i;
                    state_d        = StGetOdd;
                end
                StGetOdd: begin
                    cmd_d[CMD_ODD] = bus.din_i;
                    state_d        = StGetMsbf;
                end
                StGetMsbf: begin
                    cmd_d[CMD_MSBF] = bus.din_i;
                    sr_d            = sample;
                    dout_d          = 1'b0;
                    cnt_d           = '0;
                    state_d         = StData;
                end
                StData: begin
                    if (cmd_q[CMD_MSBF]) begin
                        dout_d = sr_q[DATA_W-1];
                        sr_d   = sr_q << 1;
                    end else begin
                        dout_d = sr_q[0];
                        sr_d   = sr_q >> 1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        done_d  = 1'b1;
                        last_d  = cmd_q;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    dout_d = IDLE_DOUT;
                    busy_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.dout_o      = dout_q;
    assign bus.busy_o      = busy_q;
    assign bus.conv_done_o = done_q;
    assign bus.last_cmd_o  = last_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: frames push expected serial patterns, a monitor checks them.
module tb_adc_responder;

    localparam int unsigned DW = 10;

    typedef struct packed {
        logic [DW:0] bits;
        logic [2:0]  cmd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_push;
    int   n_done;
    logic [DW:0] hist;
    exp_t exp_q[$];

    adc_responder_if #(.DATA_W(DW)) bus ();

    adc_responder #(
        .DATA_W    (DW),
        .IDLE_DOUT (1'b0)
    ) dut (
        .s_clk_i (clk),
        .rst_i   (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic sgl, input logic odd, input logic msbf, input int lead);
        bus.cs_i  = 1'b0;
        bus.din_i = 1'b0;
        tick();
        for (int i = 0; i < lead; i++) tick();
        bus.din_i = 1'b1; tick();
        bus.din_i = sgl;  tick();
        bus.din_i = odd;  tick();
        bus.din_i = msbf; tick();
        bus.din_i = 1'b0;
    endtask

    task automatic full_frame(input logic sgl, input logic odd, input logic msbf, input int lead,
                              input logic [DW:0] bits, input logic [2:0] cmd);
        exp_q.push_back('{bits: bits, cmd: cmd});
        n_push++;
        start_cmd(sgl, odd, msbf, lead);
        check("busy_after_cmd", 32'(bus.busy_o), 32'd1);
        repeat (DW) tick();
        tick();
        check("busy_done", 32'(bus.busy_o), 32'd0);
        check("dout_done", 32'(bus.dout_o), 32'd0);
        bus.cs_i = 1'b1;
        tick();
    endtask

    // Monitor: dout history over the null + data bits, checked on each conv_done pulse
    initial begin
        hist = '0;
        forever begin
            @(negedge clk);
            hist = {hist[DW-1:0], bus.dout_o};
            if (bus.conv_done_o) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_conv_done: got pulse, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_bits", 32'(hist), 32'(e.bits));
                    check("last_cmd", 32'(bus.last_cmd_o), 32'(e.cmd));
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_push = 0;
        n_done = 0;
        rst            = 1'b1;
        bus.cs_i       = 1'b1;
        bus.din_i      = 1'b0;
        bus.ch0_data_i = '0;
        bus.ch1_data_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_dout", 32'(bus.dout_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.conv_done_o), 32'd0);
        check("rst_last_cmd", 32'(bus.last_cmd_o), 32'd0);
        tick();

`ifdef ADC_RESP_RAMP_EN
        // ch0 ramp counts 0,1,2,... through 1023 and wraps to 0
        for (int i = 0; i < 1025; i++) begin
            logic [DW-1:0] w;
            w = DW'(i);
            full_frame(1'b1, 1'b0, 1'b1, 0, {1'b0, w}, 3'b101);
        end
`else
        // ch1 = 2A5, LSB first; input change after capture must not matter
        bus.ch1_data_i = 10'h2A5;
        exp_q.push_back('{bits: 11'b0_1010010101, cmd: 3'b110});
        n_push++;
        start_cmd(1'b1, 1'b1, 1'b0, 0);
        bus.ch1_data_i = 10'h000;
        check("busy_after_cmd", 32'(bus.busy_o), 32'd1);
        check("null_bit", 32'(bus.dout_o), 32'd0);
        repeat (DW) tick();
        tick();
        check("busy_done", 32'(bus.busy_o), 32'd0);
        bus.cs_i = 1'b1;
        tick();

        bus.ch0_data_i = 10'h001;
        full_frame(1'b1, 1'b0, 1'b1, 2, 11'b0_0000000001, 3'b101);

        bus.ch0_data_i = 10'd300;
        bus.ch1_data_i = 10'd100;
        full_frame(1'b0, 1'b0, 1'b1, 0, 11'b0_0011001000, 3'b001);

        bus.ch0_data_i = 10'd100;
        bus.ch1_data_i = 10'd300;
        full_frame(1'b0, 1'b0, 1'b1, 1, 11'b0_0000000000, 3'b001);

        full_frame(1'b0, 1'b1, 1'b0, 0, 11'b0_0001001100, 3'b010);

        // Abort after 4 data bits
        bus.ch0_data_i = 10'h3FF;
        start_cmd(1'b1, 1'b0, 1'b1, 0);
        repeat (4) tick();
        check("abort_dout_busy", 32'(bus.dout_o), 32'd1);
        bus.cs_i = 1'b1;
        tick();
        check("abort_dout", 32'(bus.dout_o), 32'd0);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_last_cmd", 32'(bus.last_cmd_o), 32'b010);
        tick();
        bus.ch0_data_i = 10'h2A5;
        full_frame(1'b1, 1'b0, 1'b1, 0, 11'b0_1010100101, 3'b101);

        // Reset in the middle of the data phase
        bus.ch1_data_i = 10'h3FF;
        start_cmd(1'b1, 1'b1, 1'b0, 0);
        repeat (3) tick();
        check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        bus.cs_i = 1'b1;
        check("mid_rst_dout", 32'(bus.dout_o), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_last_cmd", 32'(bus.last_cmd_o), 32'd0);
        tick();
        bus.ch1_data_i = 10'h155;
        full_frame(1'b1, 1'b1, 1'b0, 0, 11'b0_1010101010, 3'b110);
`endif

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
